// File: rtl/mul16_seq.sv
// mul16_seq: sequential shift-add unsigned WxW multiplier, one partial-product row per clock.
// Optional build macro MUL16_EARLY_EXIT_EN ends RUN once the remaining multiplier bits are all zero.
module mul16_seq #(
    parameter int W = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [W-1:0]   A,
    input  logic [W-1:0]   B,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] P
);
    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     mplier_q, mplier_d;
    logic [W-1:0]     mcand_q, mcand_d;
    logic [2*W-1:0]   acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2*W-1:0]   p_q, p_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [2*W-1:0]   addend;
    logic             last;

    assign addend = {{W{1'b0}}, mcand_q} << cnt_q;
`ifdef MUL16_EARLY_EXIT_EN
    assign last = (cnt_q == CW'(W - 1)) || (mplier_q[W-1:1] == '0);
`else
    assign last = (cnt_q == CW'(W - 1));
`endif

    // Next-state: accept in IDLE/DONE, one shift-add iteration per RUN cycle
    always_comb begin
        state_d  = state_q;
        mplier_d = mplier_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        p_d      = p_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        if (state_q == RUN) begin
            acc_d    = mplier_q[0] ? acc_q + addend : acc_q;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            if (last) begin
                state_d = DONE;
                p_d     = acc_d;
                done_d  = 1'b1;
            end else begin
                busy_d = 1'b1;
            end
        end else if (start) begin
            state_d  = RUN;
            mplier_d = A;
            mcand_d  = B;
            acc_d    = '0;
            cnt_d    = '0;
            busy_d   = 1'b1;
        end else begin
            state_d = IDLE;
        end
    end

    // State and registered outputs, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            mplier_q <= '0;
            mcand_q  <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            p_q      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mplier_q <= mplier_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            p_q      <= p_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign P    = p_q;
endmodule

// File: tb/tb_mul16_seq.sv
// tb_mul16_seq: directed and random checks of mul16_seq against an arithmetic reference model.
module tb_mul16_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] A = '0;
    logic [15:0] B = '0;
    logic        busy;
    logic        done;
    logic [31:0] P;
    int n_assert = 0;
    int n_fail = 0;

    mul16_seq dut (.clk(clk), .rst(rst), .start(start), .A(A), .B(B), .busy(busy), .done(done), .P(P));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] prod(input logic [15:0] a, input logic [15:0] b);
        return 64'(a) * 64'(b);
    endfunction

    // Cycles spent in RUN for multiplier a
    function automatic int lat(input logic [15:0] a);
`ifdef MUL16_EARLY_EXIT_EN
        int l = 1;
        for (int i = 0; i < 16; i++) if (a[i]) l = i + 1;
        return l;
`else
        return 16;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [15:0] a, input logic [15:0] b);
        logic [31:0] p_prev;
        int n;
        int busy_n;
        bit stable;
        p_prev = P;
        A = a;
        B = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        A = 16'($urandom);
        B = 16'($urandom);
        n = 0;
        busy_n = 0;
        stable = 1'b1;
        while (done !== 1'b1 && n < 100) begin
            if (busy === 1'b1) busy_n++;
            if (P !== p_prev) stable = 1'b0;
            tick();
            n++;
        end
        check("done_seen", 64'(done), 64'(1));
        check("latency", 64'(n), 64'(lat(a)));
        check("busy_cycles", 64'(busy_n), 64'(lat(a)));
        check("p_stable_run", 64'(stable), 64'(1));
        check("product", 64'(P), prod(a, b));
        tick();
        check("done_one_cycle", 64'(done), 64'(0));
        check("p_hold", 64'(P), prod(a, b));
    endtask

    initial begin
        int n;
        int dn;
        logic [31:0] pd;
        logic [15:0] a1, b1, a2, b2;
        repeat (2) tick();
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_done", 64'(done), 64'(0));
        check("reset_p", 64'(P), 64'(0));
        rst = 1'b0;
        tick();

        do_op(16'd3, 16'd5);
        check("p_0f", 64'(P), 64'h0F);

        #3 rst = 1'b1;
        #1;
        check("async_rst_busy", 64'(busy), 64'(0));
        check("async_rst_done", 64'(done), 64'(0));
        check("async_rst_p", 64'(P), 64'(0));
        tick();
        rst = 1'b0;
        tick();

        do_op(16'hFFFF, 16'hFFFF);
        check("p_max", 64'(P), 64'hFFFE0001);
        do_op(16'h8000, 16'h0002);
        check("p_msb", 64'(P), 64'h00010000);
        do_op(16'h0001, 16'hABCD);
        do_op(16'h0000, 16'h1234);

        A = 16'd7;
        B = 16'd9;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        A = 16'd1;
        B = 16'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        dn = 0;
        pd = '0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) begin
                dn++;
                pd = P;
            end
            tick();
        end
        check("ignored_start_pulses", 64'(dn), 64'(1));
        check("ignored_start_p", 64'(pd), 64'h3F);
        check("ignored_start_hold", 64'(P), 64'h3F);

        a1 = 16'($urandom);
        b1 = 16'($urandom);
        a2 = 16'($urandom) | 16'h8000;
        b2 = 16'($urandom);
        A = a1;
        B = b1;
        start = 1'b1;
        tick();
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check("b2b_done1", 64'(done), 64'(1));
        check("b2b_p1", 64'(P), prod(a1, b1));
        A = a2;
        B = b2;
        n = 0;
        do begin
            tick();
            n++;
        end while (done !== 1'b1 && n < 100);
        start = 1'b0;
        check("b2b_spacing", 64'(n), 64'(lat(a2) + 1));
        check("b2b_p2", 64'(P), prod(a2, b2));
        tick();

        A = 16'h1234;
        B = 16'h5678;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        #3 rst = 1'b1;
        #1;
        check("abort_p", 64'(P), 64'(0));
        check("abort_busy", 64'(busy), 64'(0));
        tick();
        rst = 1'b0;
        dn = 0;
        for (int i = 0; i < 20; i++) begin
            if (done === 1'b1) dn++;
            tick();
        end
        check("abort_no_done", 64'(dn), 64'(0));
        check("abort_p_after", 64'(P), 64'(0));
        do_op(16'h1234, 16'h5678);
        check("p_after_abort", 64'(P), 64'h06260060);

        for (int i = 0; i < 8; i++) do_op(16'($urandom), 16'($urandom));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/mul16_seq.md
# mul16_seq

Sequential shift-add multiplier controller for the unsigned 16x16 datapath. It latches two operands on a start handshake and iterates one partial-product row per clock through a single accumulator adder instead of sixteen chained adders. It delivers the 32-bit product with a one-cycle done pulse. It sits between a bus-side requester and the arithmetic unit, where area matters more than single-cycle latency.

## Interface
- W, 16, operand width; product width is 2W.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only while accepting (IDLE or DONE state).
- A  in  W  multiplier operand; latched on accepted start.
- B  in  W  multiplicand operand; latched on accepted start.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse when P is updated.
- P  out  2W  product; holds the last completed result.

## Operation
- Arithmetic is unsigned, with no overflow: P = A*B always fits in 2W bits.
- States:
  - IDLE (reset state).
  - RUN: busy=1.
  - DONE: done=1 for exactly one cycle.
- IDLE: start=1 moves to RUN.
  - Latch mplier<=A, mcand<=B, acc<=0, cnt<=0.
- RUN: each cycle performs one iteration.
  - If mplier[0]=1, acc <= acc + (mcand << cnt) (2W-bit add); otherwise acc is unchanged.
  - mplier shifts right by 1 and cnt increments.
  - After the iteration with cnt=W-1, go to DONE and load P <= final acc.
- DONE: done=1.
  - start=1 accepts a new operation immediately (same latch actions as IDLE) and goes to RUN.
  - Otherwise go to IDLE.
- start in RUN is ignored and not queued.
- A and B changes after acceptance have no effect.
- P changes only on the DONE entry edge; it is stable during RUN.
- Reset values: busy=0, done=0, P=0, state IDLE, and all internal registers cleared.
- Reset mid-RUN aborts the operation. P returns to 0, no done pulse occurs, and the block is ready for start on the first edge after rst deasserts.

## Timing
- Start is sampled at edge k. RUN covers edges k+1 .. k+W, and DONE is entered at edge k+W.
- done and the new P are visible in the cycle after edge k+W, which is W cycles after the accept edge.
- busy is high for W cycles per operation.
- Back-to-back throughput: one result per W+1 cycles (start held high through DONE).
- done deasserts at the next edge unconditionally.
- No combinational path from any input to any output; all outputs are registered.

## Configuration
- MUL16_EARLY_EXIT_EN
  - Defined: RUN leaves for DONE at the end of any iteration after which the shifted mplier is zero. RUN length = max(1, index of the most significant set bit of A + 1) cycles. A=0 takes 1 RUN cycle with P=0. Results are identical to the full-length run; only latency shrinks. busy and done follow the shortened schedule.
  - Undefined: RUN always lasts exactly W cycles regardless of operand values.

## Test plan
- Reset: assert rst mid-cycle -> busy=0, done=0, P=0 immediately (asynchronous), state IDLE.
- A=3, B=5, start one cycle -> busy high 16 cycles; then done pulses one cycle with P=0x0000000F; P holds 0x0F afterwards.
- A=0xFFFF, B=0xFFFF -> P=0xFFFE0001. A=0x8000, B=0x0002 -> P=0x00010000. Both take a 16-cycle RUN without the macro.
- Start with A=7, B=9, then pulse start with A=1, B=1 while busy -> second request ignored; P=0x3F; exactly one done pulse.
- start held high continuously with new operands presented in the DONE cycle -> second operation accepted in DONE; done pulses 17 cycles apart; both products correct.
- Reset at RUN cycle 8 of A=0x1234, B=0x5678 -> no done, P=0. A fresh start then yields 0x06260060.
- With MUL16_EARLY_EXIT_EN: A=1, B=0xABCD -> done after 1 RUN cycle, P=0x0000ABCD. A=0 -> 1 RUN cycle, P=0. A=0x8000 -> 16 RUN cycles.
